aes_core_arbiter: RTL
=====================

AES_CORE_ARBITER -- requirements
Module: aes_core_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 128, meaning the data/key width in bits.
REQ-002 The block SHALL have parameter TIMEOUT, default 64 (legal range 16..255), meaning the maximum number of WAIT cycles before a job is aborted.
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port rst_n_i, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have ports reqN_valid_i (input, 1), reqN_ready_o (output, 1), reqN_data_i (input, WIDTH) and reqN_key_i (input, WIDTH), for N = 0 and 1: the job request channel for requester N.
REQ-006 The block SHALL have ports rspN_valid_o (output, 1), rspN_ready_i (input, 1), rspN_data_o (output, WIDTH) and rspN_err_o (output, 1), for N = 0 and 1: the result channel for requester N.
REQ-007 The block SHALL have ports core_start_o (output, 1), core_data_o (output, WIDTH) and core_key_o (output, WIDTH): the start pulse, plaintext and cipher key driven to the shared AES round core.
REQ-008 The block SHALL have ports core_busy_i (input, 1), core_done_i (input, 1) and core_data_final_i (input, WIDTH): the round core status and ciphertext.

Function
REQ-009 The FSM SHALL have exactly four states: IDLE, ISSUE, WAIT and RESP; reset enters IDLE.
REQ-010 Arbitration winner in IDLE SHALL be:
  - the only requester with valid high, if exactly one is high;
  - if both are high, the requester not in last_grant.
REQ-011 last_grant SHALL reset to 1, so that requester 0 wins the first contention.
REQ-012 reqN_ready_o SHALL be high only in IDLE, only for the winner, and only while core_busy_i=0.
REQ-013 Handshake rules for reqN_ready_o:
  - it is combinational from valid and state;
  - valid dropped before ready creates no job.
REQ-014 On reqN_valid_i & reqN_ready_o, the block SHALL:
  - capture data, key and id=N into internal registers;
  - set last_grant=N;
  - go to ISSUE.
REQ-015 In ISSUE, core_start_o SHALL be 1 for exactly one cycle, after which the FSM goes to WAIT.
REQ-016 core_start_o SHALL be 0 in every other state.
REQ-017 core_data_o and core_key_o SHALL drive the captured registers, held stable from ISSUE through the end of RESP.
REQ-018 In WAIT, a watchdog counter SHALL:
  - be 8 bits wide;
  - clear on entry to WAIT;
  - increment once per WAIT cycle, saturating at 255.
REQ-019 In WAIT with core_done_i=1, the block SHALL capture core_data_final_i as the result, set err=0 and go to RESP.
REQ-020 In WAIT with core_done_i=0 and counter == TIMEOUT-1, the block SHALL set result=0, set err=1 and go to RESP.
REQ-021 core_done_i SHALL be ignored in IDLE, ISSUE and RESP.
REQ-022 When done and timeout coincide, done SHALL win.
REQ-023 In RESP, rsp[id]_valid_o SHALL be 1, with rsp[id]_data_o and rsp[id]_err_o stable until rsp[id]_ready_i=1; the other channel's valid SHALL stay 0.
REQ-024 On the RESP handshake cycle, the FSM SHALL return to IDLE, and no request SHALL be accepted in that same cycle.
REQ-025 Latency SHALL be:
  - accept to core_start_o: 1 cycle;
  - core_done_i to rsp valid: 1 cycle.
REQ-026 Only one job SHALL be outstanding at a time.
REQ-027 reqN_* inputs SHALL be ignored outside IDLE.

Reset
REQ-028 On rst_n_i=0, the block SHALL immediately (asynchronously) set the following to 0, with state=IDLE:
  - all ready, valid and err outputs;
  - core_start_o;
  - core_data_o and core_key_o;
  - rspN_data_o;
  - the captured registers and the counter.
REQ-029 On rst_n_i=0 it SHALL also set last_grant=1.
REQ-030 Reset during ISSUE, WAIT or RESP SHALL abandon the job with no response issued; a late core_done_i after release SHALL be ignored.

Verification
REQ-031 Single job: req0 with data=00112233445566778899aabbccddeeff and key=000102030405060708090a0b0c0d0e0f, core model returning done after 22 cycles -> one core_start_o pulse; rsp0 data=69c4e0d86a7b0430d8cdb78070b4c55a, err=0; rsp1_valid_o never asserted.
REQ-032 Contention: req0 and req1 held valid continuously, 4 jobs -> grant order 0,1,0,1; each response arrives on its own channel.
REQ-033 Timeout: core_done_i never asserted -> rsp valid exactly TIMEOUT cycles after WAIT entry, with data=0 and err=1; the FSM then returns to IDLE.
REQ-034 Backpressure: rsp0_ready_i held 0 for 10 cycles -> rsp0 valid, data and err stable for those 10 cycles; req1 not accepted until 1 cycle after the handshake.
REQ-035 Busy and reset: core_busy_i=1 with req1 valid -> req1_ready_o=0; rst_n_i asserted mid-WAIT -> all outputs 0 at once, and after release no response is issued.

Source files
------------

// File: rtl/aes_core_arbiter.sv
// Two-requester front end for a shared AES round core: arbitrates job requests,
// issues one job at a time to the core, and returns the result on the originating channel.
module aes_core_arbiter #(
  parameter int unsigned WIDTH   = 128,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic             clk_i,
  input  logic             rst_n_i,

  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic [WIDTH-1:0] req0_data_i,
  input  logic [WIDTH-1:0] req0_key_i,
  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic [WIDTH-1:0] req1_data_i,
  input  logic [WIDTH-1:0] req1_key_i,

  output logic             rsp0_valid_o,
  input  logic             rsp0_ready_i,
  output logic [WIDTH-1:0] rsp0_data_o,
  output logic             rsp0_err_o,
  output logic             rsp1_valid_o,
  input  logic             rsp1_ready_i,
  output logic [WIDTH-1:0] rsp1_data_o,
  output logic             rsp1_err_o,

  output logic             core_start_o,
  output logic [WIDTH-1:0] core_data_o,
  output logic [WIDTH-1:0] core_key_o,
  input  logic             core_busy_i,
  input  logic             core_done_i,
  input  logic [WIDTH-1:0] core_data_final_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] key_q, key_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             err_q, err_d;
  logic [7:0]       cnt_q, cnt_d;

  logic can_accept;
  logic win1;
  logic acc0, acc1;
  logic rsp_hs;

  // Ready is gated by rst_n_i so it drops immediately on reset even with valid high.
  always_comb begin
    can_accept   = rst_n_i & (state_q == IDLE) & ~core_busy_i;
    win1         = req1_valid_i & (~req0_valid_i | ~last_grant_q);
    req0_ready_o = can_accept & req0_valid_i & ~win1;
    req1_ready_o = can_accept & win1;
    acc0         = req0_valid_i & req0_ready_o;
    acc1         = req1_valid_i & req1_ready_o;
  end

  always_comb begin
    rsp_hs = id_q ? rsp1_ready_i : rsp0_ready_i;
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    data_d       = data_q;
    key_d        = key_q;
    result_d     = result_q;
    err_d        = err_q;
    cnt_d        = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (acc0) begin
          id_d         = 1'b0;
          data_d       = req0_data_i;
          key_d        = req0_key_i;
          last_grant_d = 1'b0;
          state_d      = ISSUE;
        end else if (acc1) begin
          id_d         = 1'b1;
          data_d       = req1_data_i;
          key_d        = req1_key_i;
          last_grant_d = 1'b1;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        // done takes priority over an expiring watchdog in the same cycle
        if (core_done_i) begin
          result_d = core_data_final_i;
          err_d    = 1'b0;
          state_d  = RESP;
        end else if (cnt_q == CNT_LAST) begin
          result_d = '0;
          err_d    = 1'b1;
          state_d  = RESP;
        end
      end
      RESP: begin
        if (rsp_hs) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      data_q       <= '0;
      key_q        <= '0;
      result_q     <= '0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      data_q       <= data_d;
      key_q        <= key_d;
      result_q     <= result_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    core_start_o = (state_q == ISSUE);
    core_data_o  = data_q;
    core_key_o   = key_q;
    rsp0_valid_o = (state_q == RESP) & ~id_q;
    rsp1_valid_o = (state_q == RESP) &  id_q;
    rsp0_err_o   = rsp0_valid_o & err_q;
    rsp1_err_o   = rsp1_valid_o & err_q;
    rsp0_data_o  = id_q ? '0 : result_q;
    rsp1_data_o  = id_q ? result_q : '0;
  end

endmodule
